regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer register file with a pending-write scoreboard, for the decode stage of the pipelined core. It provides NRD synchronous read ports with write-back bypass and one write-back port. Per-register busy bits track issued instructions whose results are not yet written back. It drives a stall signal to decode on RAW and WAW hazards. Register 0 is hardwired to zero and is never busy.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers; power of two, ≥ 2
- NRD, 2, number of read ports, 1..4
- BYPASS, 1, 1 = a write-back in the same cycle is forwarded to a read; 0 = reads see the array only
- Derived: AW = $clog2(NREG)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clk
- rd_en_i  in  1  capture read data this cycle
- rd_addr_i  in  NRD*AW  packed read addresses; port k at [k*AW +: AW]
- rd_data_o  out  NRD*XLEN  registered read data; port k at [k*XLEN +: XLEN]
- rd_busy_o  out  NRD  combinational; bit k = busy bit of rd_addr_i port k, after write-back clearing
- issue_v_i  in  1  an instruction with destination issue_rd_i requests issue
- issue_rd_i  in  AW  destination register of the issuing instruction
- stall_o  out  1  combinational; issue is refused this cycle
- wb_v_i  in  1  write-back valid
- wb_rd_i  in  AW  write-back destination
- wb_data_i  in  XLEN  write-back data

## Operation
- Storage: NREG-1 registers of XLEN bits (r1..r(NREG-1)). Reading address 0 always returns 0.
- Write: on posedge, if wb_v_i && wb_rd_i != 0, then mem[wb_rd_i] <= wb_data_i. Writes to register 0 are discarded.
- Read, per port k: on posedge with rd_en_i, rd_data_o[k] is loaded with:
  - 0 if the address is 0;
  - otherwise wb_data_i, if BYPASS && wb_v_i && wb_rd_i == address;
  - otherwise mem[address].
- With rd_en_i = 0, rd_data_o holds its value.
- Busy bits busy[NREG-1:1]; busy[0] is constant 0.
- eff_busy(a) = busy[a] && !(wb_v_i && wb_rd_i == a && BYPASS).
- rd_busy_o[k] = eff_busy(rd_addr_i port k).
- stall_o = issue_v_i && (any rd_busy_o[k] || eff_busy(issue_rd_i)). All NRD ports are checked; the caller drives unused ports to 0.
- Issue accepted = issue_v_i && !stall_o. On acceptance with issue_rd_i != 0, busy[issue_rd_i] <= 1.
- Write-back clears the busy bit: busy[wb_rd_i] <= 0 when wb_v_i.
- Simultaneous accepted issue and write-back to the same register: the set wins and the busy bit stays 1.
- Write-back to a register that is not busy: data is written and busy stays 0. This is not an error.
- The block does not reorder writes. The caller guarantees at most one outstanding write per register, and stall_o enforces this.

## Timing
- Read latency: 1 cycle. Address at edge N produces data after edge N.
- Write-to-read: with BYPASS=1, the same-edge read sees the new data. With BYPASS=0, the read sees it one cycle later.
- stall_o and rd_busy_o are combinational from this cycle's inputs and the current busy state. There is no registered stall.
- Reset, at the posedge with reset=1:
  - all registers go to 0, all busy bits to 0, rd_data_o to 0;
  - reset overrides write-back, issue and read in the same cycle;
  - reset mid-operation drops all pending busy bits. Later write-backs to those registers still write their data.
- During reset, stall_o and rd_busy_o reflect pre-reset state. Decode must not issue while reset is high.

## Test plan
- Reset and x0:
  - assert reset for 1 cycle, then read all registers → all 0, busy_o all 0.
  - wb x0 = 0xDEADBEEF, then read x0 → 0.
  - issue rd=0 → stall_o 0, no busy set.
- Basic write/read: wb x5 = 0x12345678 at edge N. Read x5 at edge N+1 → rd_data_o = 0x12345678 after edge N+1. Port 1 reading x6 at the same time → 0.
- Bypass:
  - BYPASS=1: wb x7 = 0xA5A5A5A5 and read x7 on the same edge → 0xA5A5A5A5.
  - BYPASS=0: same stimulus → old value 0; the following read → 0xA5A5A5A5.
- RAW stall:
  - issue rd=x3 (accepted), then issue with read port 0 = x3 → stall_o = 1, rd_busy_o[0] = 1.
  - wb x3 = 0x55 in a later cycle → with BYPASS=1, stall_o drops that same cycle; with BYPASS=0, it drops next cycle.
- WAW and simultaneous events:
  - issue x9 accepted, then issue x9 again → stall_o = 1.
  - wb x9 and issue x9 in the same cycle (BYPASS=1) → accepted; busy[9] remains 1 afterwards.
- Reset mid-operation: set busy on x4 and x12, assert reset → busy bits clear. Then wb x4 = 0x99 → data written, read returns 0x99, busy stays 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Decode-stage integer register file with NRD registered read ports, one write-back
// port and a per-register pending-write scoreboard that drives the issue stall.

module regfile_sb_rdport #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rd_en,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_v,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] data
);
  logic wb_hit;

  assign wb_hit = (BYPASS != 0) && wb_v && (wb_rd == addr);

  always_ff @(posedge clk) begin
    if (reset)               data <= '0;
    else if (rd_en) begin
      if (addr == '0)        data <= '0;
      else if (wb_hit)       data <= wb_data;
      else                   data <= mem_data;
    end
  end
endmodule

module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en_i,
  input  logic [NRD*AW-1:0]     rd_addr_i,
  output logic [NRD*XLEN-1:0]   rd_data_o,
  output logic [NRD-1:0]        rd_busy_o,
  input  logic                  issue_v_i,
  input  logic [AW-1:0]         issue_rd_i,
  output logic                  stall_o,
  input  logic                  wb_v_i,
  input  logic [AW-1:0]         wb_rd_i,
  input  logic [XLEN-1:0]       wb_data_i
);
  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] wb_mask;
  logic [NREG-1:0] eff_busy;
  logic            accept;

  // A same-cycle write-back only hides the busy bit when its data can be forwarded.
  always_comb begin
    wb_mask = '0;
    if (wb_v_i && (BYPASS != 0)) wb_mask[wb_rd_i] = 1'b1;
  end

  assign eff_busy = busy & ~wb_mask;
  assign stall_o  = issue_v_i && ((|rd_busy_o) || eff_busy[issue_rd_i]);
  assign accept   = issue_v_i && !stall_o;

  genvar k;
  generate
    for (k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] addr;
      assign addr         = rd_addr_i[k*AW +: AW];
      assign rd_busy_o[k] = eff_busy[addr];

      regfile_sb_rdport #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rd (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (rd_en_i),
        .addr     (addr),
        .mem_data (mem[addr]),
        .wb_v     (wb_v_i),
        .wb_rd    (wb_rd_i),
        .wb_data  (wb_data_i),
        .data     (rd_data_o[k*XLEN +: XLEN])
      );
    end
  endgenerate

  // Entry 0 is only ever loaded with zero; reads of x0 are forced to zero in the port anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wb_v_i && (wb_rd_i != '0)) begin
      mem[wb_rd_i] <= wb_data_i;
    end
  end

  // Set is ordered after clear so an accepted issue beats a same-register write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (wb_v_i)                       busy[wb_rd_i]    <= 1'b0;
      if (accept && (issue_rd_i != '0)) busy[issue_rd_i] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Random and directed bench for regfile_sb: one instance with bypass, one without,
// both compared every cycle against an array-based scoreboard model.

module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                rd_en = 1'b0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic                issue_v = 1'b0;
  logic [AW-1:0]       issue_rd = '0;
  logic                wb_v = 1'b0;
  logic [AW-1:0]       wb_rd = '0;
  logic [XLEN-1:0]     wb_data = '0;

  logic [NRD*XLEN-1:0] rd_data_b0, rd_data_b1;
  logic [NRD-1:0]      rd_busy_b0, rd_busy_b1;
  logic                stall_b0, stall_b1;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data_b0), .rd_busy_o(rd_busy_b0), .issue_v_i(issue_v),
    .issue_rd_i(issue_rd), .stall_o(stall_b0), .wb_v_i(wb_v), .wb_rd_i(wb_rd),
    .wb_data_i(wb_data));

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data_b1), .rd_busy_o(rd_busy_b1), .issue_v_i(issue_v),
    .issue_rd_i(issue_rd), .stall_o(stall_b1), .wb_v_i(wb_v), .wb_rd_i(wb_rd),
    .wb_data_i(wb_data));

  always #5 clk = ~clk;

  // Reference state, index [b] = BYPASS value of the instance.
  logic [XLEN-1:0] m_mem  [2][NREG];
  bit              m_busy [2][NREG];
  logic [XLEN-1:0] m_rd   [2][NRD];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int port_addr(input int k);
    return int'(rd_addr[k*AW +: AW]);
  endfunction

  function automatic bit m_eff(input int b, input int a);
    return m_busy[b][a] && !(wb_v && int'(wb_rd) == a && b == 1);
  endfunction

  function automatic bit m_stall(input int b);
    bit s;
    s = m_eff(b, int'(issue_rd));
    for (int k = 0; k < NRD; k++) s |= m_eff(b, port_addr(k));
    return issue_v && s;
  endfunction

  function automatic logic [NRD*XLEN-1:0] dut_data(input int b);
    return (b == 0) ? rd_data_b0 : rd_data_b1;
  endfunction

  function automatic logic [NRD-1:0] dut_busy(input int b);
    return (b == 0) ? rd_busy_b0 : rd_busy_b1;
  endfunction

  function automatic logic dut_stall(input int b);
    return (b == 0) ? stall_b0 : stall_b1;
  endfunction

  task automatic m_clear();
    for (int b = 0; b < 2; b++) begin
      for (int r = 0; r < NREG; r++) begin
        m_mem[b][r] = '0;
        m_busy[b][r] = 1'b0;
      end
      for (int k = 0; k < NRD; k++) m_rd[b][k] = '0;
    end
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic step();
    bit st [2];
    logic [NRD*XLEN-1:0] d;
    logic [NRD-1:0] bz;
    #1;
    for (int b = 0; b < 2; b++) begin
      bz = dut_busy(b);
      for (int k = 0; k < NRD; k++)
        chk($sformatf("rd_busy b%0d p%0d", b, k), 64'(bz[k]), 64'(m_eff(b, port_addr(k))));
      st[b] = m_stall(b);
      chk($sformatf("stall b%0d", b), 64'(dut_stall(b)), 64'(st[b]));
    end
    @(posedge clk);
    for (int b = 0; b < 2; b++) begin
      if (reset) begin
        for (int r = 0; r < NREG; r++) begin
          m_mem[b][r] = '0;
          m_busy[b][r] = 1'b0;
        end
        for (int k = 0; k < NRD; k++) m_rd[b][k] = '0;
      end else begin
        if (rd_en)
          for (int k = 0; k < NRD; k++) begin
            int a = port_addr(k);
            if (a == 0)                                  m_rd[b][k] = '0;
            else if (b == 1 && wb_v && int'(wb_rd) == a) m_rd[b][k] = wb_data;
            else                                         m_rd[b][k] = m_mem[b][a];
          end
        if (wb_v && wb_rd != 0) m_mem[b][wb_rd] = wb_data;
        if (wb_v)               m_busy[b][wb_rd] = 1'b0;
        if (issue_v && !st[b] && issue_rd != 0) m_busy[b][issue_rd] = 1'b1;
      end
    end
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      d = dut_data(b);
      for (int k = 0; k < NRD; k++)
        chk($sformatf("rd_data b%0d p%0d", b, k), 64'(d[k*XLEN +: XLEN]), 64'(m_rd[b][k]));
    end
  endtask

  task automatic drv(input bit rs, input bit re, input int a0, input int a1,
                     input bit iv, input int ird, input bit wv, input int wr,
                     input logic [XLEN-1:0] wd);
    reset    = rs;
    rd_en    = re;
    rd_addr  = {a1[AW-1:0], a0[AW-1:0]};
    issue_v  = iv;
    issue_rd = ird[AW-1:0];
    wb_v     = wv;
    wb_rd    = wr[AW-1:0];
    wb_data  = wd;
    step();
  endtask

  initial begin
    logic [NRD*XLEN-1:0] d;
    m_clear();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Reset contents and x0 behaviour
    for (int r = 0; r < NREG; r += 2) drv(0, 1, r, r + 1, 0, 0, 0, 0, '0);
    drv(0, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF);
    drv(0, 1, 0, 0, 0, 0, 0, 0, '0);
    d = rd_data_b1;
    chk("x0 after wb", 64'(d[XLEN-1:0]), 64'h0);
    drv(0, 0, 0, 0, 1, 0, 0, 0, '0);
    drv(0, 0, 0, 0, 1, 0, 0, 0, '0);

    // Basic write then read, port 1 reads an unwritten register
    drv(0, 0, 0, 0, 0, 0, 1, 5, 32'h12345678);
    drv(0, 1, 5, 6, 0, 0, 0, 0, '0);
    d = rd_data_b1;
    chk("x5 read", 64'(d[XLEN-1:0]), 64'h12345678);
    chk("x6 read", 64'(d[2*XLEN-1:XLEN]), 64'h0);

    // Same-edge write and read: forwarded only with bypass
    drv(0, 1, 7, 0, 0, 0, 1, 7, 32'hA5A5A5A5);
    d = rd_data_b1;
    chk("x7 bypass", 64'(d[XLEN-1:0]), 64'hA5A5A5A5);
    d = rd_data_b0;
    chk("x7 no bypass", 64'(d[XLEN-1:0]), 64'h0);
    drv(0, 1, 7, 0, 0, 0, 0, 0, '0);
    d = rd_data_b0;
    chk("x7 next read", 64'(d[XLEN-1:0]), 64'hA5A5A5A5);

    // RAW: x3 pending, dependent issue stalls until write-back
    drv(0, 0, 0, 0, 1, 3, 0, 0, '0);
    drv(0, 0, 3, 0, 1, 10, 0, 0, '0);
    drv(0, 0, 3, 0, 1, 10, 0, 0, '0);
    drv(0, 0, 3, 0, 1, 10, 1, 3, 32'h55);
    drv(0, 0, 3, 0, 1, 11, 0, 0, '0);
    drv(0, 0, 0, 0, 0, 0, 1, 10, 32'h1);
    drv(0, 0, 0, 0, 0, 0, 1, 11, 32'h2);

    // WAW and simultaneous issue/write-back
    drv(0, 0, 0, 0, 1, 9, 0, 0, '0);
    drv(0, 0, 0, 0, 1, 9, 0, 0, '0);
    drv(0, 0, 0, 0, 1, 9, 1, 9, 32'h77);
    drv(0, 0, 9, 9, 0, 0, 0, 0, '0);
    chk("busy9 kept", 64'(rd_busy_b1), 64'h3);

    // Reset while registers are pending
    drv(0, 0, 0, 0, 1, 4, 0, 0, '0);
    drv(0, 0, 0, 0, 1, 12, 0, 0, '0);
    drv(1, 1, 4, 12, 0, 0, 0, 0, '0);
    drv(0, 0, 4, 12, 0, 0, 1, 4, 32'h99);
    drv(0, 1, 4, 12, 0, 0, 0, 0, '0);
    d = rd_data_b0;
    chk("x4 after reset", 64'(d[XLEN-1:0]), 64'h99);
    chk("busy after reset", 64'(rd_busy_b0), 64'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit rs = ($urandom_range(0, 59) == 0);
      drv(rs, bit'($urandom_range(0, 1)),
          int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
          rs ? 1'b0 : bit'($urandom_range(0, 1)), int'($urandom_range(0, NREG - 1)),
          bit'($urandom_range(0, 1)), int'($urandom_range(0, NREG - 1)), $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
